// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM-to-writeback result bus and register-file write port
interface writeback_stage_if;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        mem_beat;
    logic [31:0] alu_result;
    logic [31:0] alu_result_hi;
    logic [4:0]  dest_reg;
    logic        memToReg;
    logic        regWrite_in;
    logic        regwrite_float_in;
    logic        double_in;
    logic        load_double;
    logic        flush;

    logic [31:0] wData;
    logic [31:0] wData2;
    logic [4:0]  wReg;
    logic        regWSig;
    logic        regwrite_float;
    logic        double;
    logic        wb_busy;
    logic        wb_err;

    modport master (
        output mem_valid, mem_data, mem_beat, alu_result, alu_result_hi, dest_reg,
               memToReg, regWrite_in, regwrite_float_in, double_in, load_double, flush,
        input  wData, wData2, wReg, regWSig, regwrite_float, double, wb_busy, wb_err
    );

    modport slave (
        input  mem_valid, mem_data, mem_beat, alu_result, alu_result_hi, dest_reg,
               memToReg, regWrite_in, regwrite_float_in, double_in, load_double, flush,
        output wData, wData2, wReg, regWSig, regwrite_float, double, wb_busy, wb_err
    );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback stage with two-beat double-load assembly
module writeback_stage #(
    parameter int HI_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    writeback_stage_if.slave    wb
);
    localparam int CW = $clog2(HI_TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [31:0] lo_data, lo_data_n;
    logic [4:0]  lo_reg, lo_reg_n;
    logic [31:0] wd_q, wd_n, wd2_q, wd2_n;
    logic [4:0]  wr_q, wr_n;
    logic        rw_q, rw_n, fw_q, fw_n, dbl_q, dbl_n, err_q, err_n;

    logic        take_new, emit;
    logic [31:0] c_lo, c_hi;
    logic [4:0]  c_reg;
    logic        c_int, c_flt, c_dbl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            lo_data <= '0;
            lo_reg  <= '0;
            wd_q    <= '0;
            wd2_q   <= '0;
            wr_q    <= '0;
            rw_q    <= 1'b0;
            fw_q    <= 1'b0;
            dbl_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            lo_data <= lo_data_n;
            lo_reg  <= lo_reg_n;
            wd_q    <= wd_n;
            wd2_q   <= wd2_n;
            wr_q    <= wr_n;
            rw_q    <= rw_n;
            fw_q    <= fw_n;
            dbl_q   <= dbl_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cnt_inc   = cnt + 1'b1;
        lo_data_n = lo_data;
        lo_reg_n  = lo_reg;
        wd_n      = wd_q;
        wd2_n     = wd2_q;
        wr_n      = wr_q;
        rw_n      = 1'b0;
        fw_n      = 1'b0;
        dbl_n     = 1'b0;
        err_n     = 1'b0;
        take_new  = 1'b0;
        emit      = 1'b0;
        c_lo      = '0;
        c_hi      = '0;
        c_reg     = '0;
        c_int     = 1'b0;
        c_flt     = 1'b0;
        c_dbl     = 1'b0;

        if (wb.flush) begin
            state_n = IDLE;
        end else if (state == HI) begin
            if (!wb.mem_valid) begin
                cnt_n = cnt_inc;
                if (cnt_inc == CW'(HI_TIMEOUT)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end else if (wb.load_double && wb.mem_beat) begin
                emit    = 1'b1;
                c_lo    = lo_data;
                c_hi    = wb.mem_data;
                c_reg   = lo_reg;
                c_flt   = 1'b1;
                c_dbl   = 1'b1;
                state_n = IDLE;
            end else begin
                // Out-of-order beat: abandon the half load, then treat the input as fresh.
                err_n    = 1'b1;
                state_n  = IDLE;
                take_new = 1'b1;
            end
        end else if (wb.mem_valid) begin
            take_new = 1'b1;
        end

        if (take_new) begin
            if (wb.load_double) begin
                if (!wb.mem_beat) begin
                    lo_data_n = wb.mem_data;
                    lo_reg_n  = wb.dest_reg;
                    cnt_n     = '0;
                    state_n   = HI;
                end else begin
                    err_n = 1'b1;
                end
            end else begin
                emit  = 1'b1;
                c_lo  = wb.memToReg ? wb.mem_data : wb.alu_result;
                c_hi  = wb.alu_result_hi;
                c_reg = wb.dest_reg;
                c_int = wb.regWrite_in;
                c_flt = wb.regwrite_float_in;
                c_dbl = wb.double_in;
            end
        end

        // Register pairs must start on an even index; integer $zero is never written.
        if (emit) begin
            if (c_dbl && c_reg[0]) begin
                err_n = 1'b1;
            end else begin
                wd_n  = c_lo;
                wd2_n = c_hi;
                wr_n  = c_reg;
                rw_n  = c_int && (c_reg != 5'd0);
                fw_n  = c_flt;
                dbl_n = c_dbl;
            end
        end
    end

    assign wb.wData          = wd_q;
    assign wb.wData2         = wd2_q;
    assign wb.wReg           = wr_q;
    assign wb.regWSig        = rw_q;
    assign wb.regwrite_float = fw_q;
    assign wb.double         = dbl_q;
    assign wb.wb_err         = err_q;
    assign wb.wb_busy        = (state == HI);
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed vector and sequence checks for writeback_stage
module tb_writeback_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    writeback_stage_if bus ();
    writeback_stage #(.HI_TIMEOUT(8)) dut (.clk(clk), .reset(reset), .wb(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        mv, ld, bt, m2r, rw, fw, dbl;
        logic [31:0] md, alu, hi;
        logic [4:0]  dest;
        logic        chk_data;
        logic [31:0] e_wd, e_wd2;
        logic [4:0]  e_wr;
        logic        e_rw, e_fw, e_dbl, e_err;
    } vec_t;

    vec_t v [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic mv, input logic ld, input logic bt, input logic [31:0] md,
                       input logic [31:0] alu, input logic [31:0] hi, input logic [4:0] dest,
                       input logic m2r, input logic rw, input logic fw, input logic dbl,
                       input logic fl);
        bus.mem_valid = mv; bus.load_double = ld; bus.mem_beat = bt; bus.mem_data = md;
        bus.alu_result = alu; bus.alu_result_hi = hi; bus.dest_reg = dest; bus.memToReg = m2r;
        bus.regWrite_in = rw; bus.regwrite_float_in = fw; bus.double_in = dbl; bus.flush = fl;
    endtask

    task automatic idle();
        drv(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(input logic b, input logic [31:0] md, input logic [4:0] dest);
        drv(1, 1, b, md, 32'h0, 32'h0, dest, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_en(input string tag, input logic erw, input logic efw, input logic edbl,
                          input logic eerr, input logic ebusy);
        check({tag, ".regWSig"}, 32'(bus.regWSig), 32'(erw));
        check({tag, ".regwrite_float"}, 32'(bus.regwrite_float), 32'(efw));
        check({tag, ".double"}, 32'(bus.double), 32'(edbl));
        check({tag, ".wb_err"}, 32'(bus.wb_err), 32'(eerr));
        check({tag, ".wb_busy"}, 32'(bus.wb_busy), 32'(ebusy));
    endtask

    initial begin
        v[0] = '{1,0,0,0,1,0,0, 32'h0, 32'hAB, 32'h0, 5'd5, 1, 32'hAB, 32'h0, 5'd5, 1,0,0,0};
        v[1] = '{0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'hAB, 32'h0, 5'd5, 0,0,0,0};
        v[2] = '{1,0,0,1,1,0,0, 32'hDEADBEEF, 32'h5, 32'h6, 5'd9, 1, 32'hDEADBEEF, 32'h6, 5'd9, 1,0,0,0};
        v[3] = '{1,0,0,0,1,0,0, 32'h0, 32'h33, 32'h44, 5'd0, 1, 32'h33, 32'h44, 5'd0, 0,0,0,0};
        v[4] = '{1,0,0,0,0,1,0, 32'h0, 32'h3F800000, 32'h0, 5'd0, 1, 32'h3F800000, 32'h0, 5'd0, 0,1,0,0};
        v[5] = '{1,0,0,0,0,1,1, 32'h0, 32'h1, 32'h2, 5'd3, 1, 32'h3F800000, 32'h0, 5'd0, 0,0,0,1};
        v[6] = '{1,0,0,0,0,1,1, 32'h0, 32'h1, 32'h2, 5'd6, 1, 32'h1, 32'h2, 5'd6, 0,1,1,0};
        v[7] = '{0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'h1, 32'h2, 5'd6, 0,0,0,0};
        v[8] = '{1,1,1,0,0,0,0, 32'h99, 32'h0, 32'h0, 5'd8, 1, 32'h1, 32'h2, 5'd6, 0,0,0,1};

        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        check("rst.wData", bus.wData, 32'h0);
        check("rst.wData2", bus.wData2, 32'h0);
        check("rst.wReg", 32'(bus.wReg), 32'h0);
        chk_en("rst", 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drv(v[i].mv, v[i].ld, v[i].bt, v[i].md, v[i].alu, v[i].hi, v[i].dest,
                v[i].m2r, v[i].rw, v[i].fw, v[i].dbl, 0);
            @(negedge clk);
            if (v[i].chk_data) begin
                check($sformatf("vec%0d.wData", i), bus.wData, v[i].e_wd);
                check($sformatf("vec%0d.wData2", i), bus.wData2, v[i].e_wd2);
                check($sformatf("vec%0d.wReg", i), 32'(bus.wReg), 32'(v[i].e_wr));
            end
            chk_en($sformatf("vec%0d", i), v[i].e_rw, v[i].e_fw, v[i].e_dbl, v[i].e_err, 0);
        end

        // Double load with a one-cycle gap between beats
        beat(0, 32'h11111111, 5'd4);
        @(negedge clk); chk_en("dl.beat0", 0, 0, 0, 0, 1);
        idle();
        @(negedge clk); chk_en("dl.gap", 0, 0, 0, 0, 1);
        beat(1, 32'h22222222, 5'd0);
        @(negedge clk);
        chk_en("dl.write", 0, 1, 1, 0, 0);
        check("dl.wReg", 32'(bus.wReg), 32'd4);
        check("dl.wData", bus.wData, 32'h11111111);
        check("dl.wData2", bus.wData2, 32'h22222222);
        idle();
        @(negedge clk); chk_en("dl.after", 0, 0, 0, 0, 0);

        // Timeout: eight empty cycles after beat 0
        beat(0, 32'h55555555, 5'd10);
        @(negedge clk);
        idle();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk_en($sformatf("to.wait%0d", c), 0, 0, 0, 0, 1);
        end
        @(negedge clk); chk_en("to.expire", 0, 0, 0, 1, 0);
        @(negedge clk); chk_en("to.after", 0, 0, 0, 0, 0);

        // Beat 0 interrupted by an integer op
        beat(0, 32'h66666666, 5'd4);
        @(negedge clk);
        drv(1, 0, 0, 32'h0, 32'h77, 32'h0, 5'd7, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk_en("intr", 1, 0, 0, 1, 0);
        check("intr.wReg", 32'(bus.wReg), 32'd7);
        check("intr.wData", bus.wData, 32'h77);

        // Beat 0 then flush with a valid op that must be ignored
        beat(0, 32'h88888888, 5'd2);
        @(negedge clk);
        drv(1, 0, 0, 32'h0, 32'hCC, 32'h0, 5'd9, 0, 1, 0, 0, 1);
        @(negedge clk);
        chk_en("flush", 0, 0, 0, 0, 0);
        check("flush.wReg", 32'(bus.wReg), 32'd7);
        idle();

        // Reset while waiting for beat 1
        beat(0, 32'h99999999, 5'd12);
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk_en("rstHI", 0, 0, 0, 0, 0);
        check("rstHI.wData", bus.wData, 32'h0);
        check("rstHI.wReg", 32'(bus.wReg), 32'h0);
        reset = 1'b0;
        beat(1, 32'hAAAAAAAA, 5'd0);
        @(negedge clk);
        chk_en("rstHI.beat1", 0, 0, 0, 1, 0);
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
